// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants for the shift command queue
// Purpose: ALU control encodings understood by barrelshifter32 and the
//          width of one packed command word {a, b, aluc, tag}.
// Ports:   none (package).
package shift_pkg;

  localparam logic [1:0] ALUC_SRA  = 2'b00;
  localparam logic [1:0] ALUC_SRL  = 2'b01;
  localparam logic [1:0] ALUC_SLL  = 2'b10;
  localparam logic [1:0] ALUC_SLL2 = 2'b11;

  // a (32) + b (5) + aluc (2); the caller tag is appended below it
  localparam int SHIFT_CMD_BASE_W = 32 + 5 + 2;

  function automatic int shift_cmd_w(input int tag_w);
    return SHIFT_CMD_BASE_W + tag_w;
  endfunction

endpackage

// File: rtl/barrelshifter32.sv
// rtl/barrelshifter32.sv - combinational 32-bit barrel shifter
// Purpose: shifts a by b according to aluc (SRA fills with a[31], SRL and
//          SLL fill with zero; b=0 passes a through).
// Ports:   a    in  32  operand
//          b    in  5   shift amount
//          aluc in  2   operation select
//          c    out 32  result
module barrelshifter32
  import shift_pkg::*;
(
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [1:0]  aluc,
  output logic [31:0] c
);

  always_comb begin
    c = a;
    case (aluc)
      ALUC_SRA:  c = $unsigned($signed(a) >>> b);
      ALUC_SRL:  c = a >> b;
      ALUC_SLL:  c = a << b;
      ALUC_SLL2: c = a << b;
      default:   c = a;
    endcase
  end

endmodule

// File: rtl/shift_cmd_fifo.sv
// rtl/shift_cmd_fifo.sv - generic DEPTH x W synchronous FIFO
// Purpose: command storage for the shift queue; head is read combinationally.
// Ports:   clk   in   1                single clock
//          rst   in   1                synchronous active-high reset
//          push  in   1                write din (ignored when full)
//          pop   in   1                drop head (ignored when empty)
//          din   in   W                write data
//          dout  out  W                current head entry
//          count out  $clog2(DEPTH+1)  occupancy
//          full  out  1                count == DEPTH
//          empty out  1                count == 0
module shift_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  // Full blocks a write even when a pop happens in the same cycle.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reads are qualified by count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/shift_cmd_queue.sv
// rtl/shift_cmd_queue.sv - buffered, back-pressurable issue stage for barrelshifter32
// Purpose: queues shift commands, shifts the FIFO head and holds the result
//          with its tag in a registered output stage.
// Config:  SHIFTQ_ZERO_FLAG_EN adds out_zero (result == 0), registered with out_c.
// Ports:   clk       in   1      single clock
//          rst       in   1      synchronous active-high reset
//          in_valid  in   1      command present
//          in_ready  out  1      queue can accept
//          in_a      in   32     operand
//          in_b      in   5      shift amount
//          in_aluc   in   2      00 SRA, 01 SRL, 1x SLL
//          in_tag    in   TAG_W  caller id
//          out_valid out  1      result register holds data
//          out_ready in   1      consumer takes result
//          out_c     out  32     shifted result
//          out_tag   out  TAG_W  tag of out_c
//          count     out  $clog2(DEPTH+1)  FIFO occupancy
//          out_zero  out  1      (SHIFTQ_ZERO_FLAG_EN only) out_c == 0
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [4:0]                 in_b,
  input  logic [1:0]                 in_aluc,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_c,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef SHIFTQ_ZERO_FLAG_EN
  ,
  output logic                       out_zero
`endif
);

  localparam int CMD_W = shift_cmd_w(TAG_W);

  logic [CMD_W-1:0] w_din;
  logic [CMD_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_load;

  logic [31:0]      w_head_a;
  logic [4:0]       w_head_b;
  logic [1:0]       w_head_aluc;
  logic [TAG_W-1:0] w_head_tag;
  logic [31:0]      w_shift_c;

  logic             r_out_valid;
  logic [31:0]      r_out_c;
  logic [TAG_W-1:0] r_out_tag;

  // Command word layout, MSB first: a, b, aluc, tag.
  assign w_din       = {in_a, in_b, in_aluc, in_tag};
  assign w_head_a    = w_head[CMD_W-1 -: 32];
  assign w_head_b    = w_head[TAG_W+6 -: 5];
  assign w_head_aluc = w_head[TAG_W+1 -: 2];
  assign w_head_tag  = w_head[TAG_W-1:0];

  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;
  // Refill the output register whenever it is empty or being drained.
  assign w_load   = ~w_empty & (~r_out_valid | out_ready);

  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_load),
    .din   (w_din),
    .dout  (w_head),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  barrelshifter32 u_shifter (
    .a    (w_head_a),
    .b    (w_head_b),
    .aluc (w_head_aluc),
    .c    (w_shift_c)
  );

  // Data and tag hold their last value after a drain; only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_c     <= '0;
      r_out_tag   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_c     <= w_shift_c;
      r_out_tag   <= w_head_tag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_c     = r_out_c;
  assign out_tag   = r_out_tag;

`ifdef SHIFTQ_ZERO_FLAG_EN
  logic r_out_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_zero <= 1'b0;
    end else if (w_load) begin
      r_out_zero <= (w_shift_c == 32'h0);
    end
  end

  assign out_zero = r_out_zero;
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// tb/tb_shift_cmd_queue.sv - scoreboard bench for shift_cmd_queue
module tb_shift_cmd_queue;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_b;
  logic [1:0]  in_aluc;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [3:0]  out_tag;
  logic [2:0]  count;
`ifdef SHIFTQ_ZERO_FLAG_EN
  logic        out_zero;
`endif

  shift_cmd_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_aluc   (in_aluc),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_tag   (out_tag),
    .count     (count)
`ifdef SHIFTQ_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_c_cur;
  int          total = 0;
  int          bad = 0;
  int          accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare each transferred result; record each accepted command.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual_tag=%h required=none", out_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_c", out_c, e.c);
          chk("out_tag", {28'h0, out_tag}, {28'h0, e.tag});
`ifdef SHIFTQ_ZERO_FLAG_EN
          chk("out_zero", {31'h0, out_zero}, {31'h0, (e.c == 32'h0)});
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({exp_c_cur, in_tag});
        accepted++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the command is taken.
  task automatic send(input logic [31:0] a, input logic [4:0] b, input logic [1:0] al,
                      input logic [3:0] tag, input logic [31:0] exp);
    bit ok;
    ok = 0;
    in_a = a; in_b = b; in_aluc = al; in_tag = tag; exp_c_cur = exp;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout tag=%h actual=stalled required=accepted", tag);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_aluc = '0; in_tag = '0;
    out_ready = 1'b1; exp_c_cur = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_c", out_c, 32'h0);
    chk("rst_out_tag", {28'h0, out_tag}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // 1: SRA latency
    @(posedge clk); #1;
    in_a = 32'h80000000; in_b = 5'd4; in_aluc = ALUC_SRA; in_tag = 4'd1;
    exp_c_cur = 32'hF8000000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid_n1", {31'h0, out_valid}, 32'h0);
    chk("lat_count_n1", {29'h0, count}, 32'h1);
    @(negedge clk);
    chk("lat_valid_n2", {31'h0, out_valid}, 32'h1);
    chk("lat_c_n2", out_c, 32'hF8000000);
    chk("lat_tag_n2", {28'h0, out_tag}, 32'h1);
    idle(2);

    // 2: SRL full width and SLL to zero
    send(32'hFFFFFFFF, 5'd31, ALUC_SRL, 4'd2, 32'h00000001);
    send(32'h80000000, 5'd1, ALUC_SLL, 4'd3, 32'h00000000);
    idle(4);

    // 3: capacity under stall, then ordered drain
    out_ready = 1'b0;
    base = accepted;
    in_a = 32'h000000F0; in_b = 5'd4; in_aluc = ALUC_SRL; exp_c_cur = 32'h0000000F;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_tag = 4'(accepted - base);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("cap_accepted", 32'(accepted - base), 32'd5);
    chk("cap_in_ready", {31'h0, in_ready}, 32'h0);
    chk("cap_count", {29'h0, count}, 32'h4);
    chk("cap_out_c", out_c, 32'h0000000F);
    chk("cap_out_tag", {28'h0, out_tag}, 32'h0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_valid", {31'h0, out_valid}, 32'h1);
    end
    @(negedge clk);
    chk("drain_done", {31'h0, out_valid}, 32'h0);
    idle(1);

    // 4: simultaneous push and pop at count=2
    out_ready = 1'b0;
    send(32'h00000003, 5'd2, ALUC_SLL, 4'd1, 32'h0000000C);
    send(32'h00000100, 5'd8, ALUC_SRL, 4'd2, 32'h00000001);
    send(32'hC0000000, 5'd2, ALUC_SRA, 4'd3, 32'hF0000000);
    @(negedge clk);
    chk("pp_count_before", {29'h0, count}, 32'h2);
    chk("pp_valid_before", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_a = 32'h00000001; in_b = 5'd31; in_aluc = ALUC_SLL2; in_tag = 4'd4;
    exp_c_cur = 32'h80000000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_after", {29'h0, count}, 32'h2);
    idle(6);

    // 5: reset discards queued work
    out_ready = 1'b0;
    send(32'h1, 5'd0, ALUC_SLL, 4'd5, 32'h1);
    send(32'h2, 5'd0, ALUC_SLL, 4'd6, 32'h2);
    send(32'h3, 5'd0, ALUC_SLL, 4'd7, 32'h3);
    send(32'h4, 5'd0, ALUC_SLL, 4'd8, 32'h4);
    @(negedge clk);
    chk("prerst_count", {29'h0, count}, 32'h3);
    chk("prerst_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("postrst_count", {29'h0, count}, 32'h0);
    chk("postrst_valid", {31'h0, out_valid}, 32'h0);
    chk("postrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("postrst_out_tag", {28'h0, out_tag}, 32'h0);
    out_ready = 1'b1;
    idle(4);
    send(32'h00000001, 5'd1, ALUC_SLL, 4'd15, 32'h00000002);
    idle(3);

    // 6: b=0 passes through for every aluc
    send(32'h12345678, 5'd0, ALUC_SRA, 4'd10, 32'h12345678);
    send(32'h12345678, 5'd0, ALUC_SRL, 4'd11, 32'h12345678);
    send(32'h12345678, 5'd0, ALUC_SLL, 4'd12, 32'h12345678);
    send(32'h12345678, 5'd0, ALUC_SLL2, 4'd13, 32'h12345678);
    idle(5);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
